// File: rtl/life_pkg.sv
// Shared state encoding, B3/S23 rule constants and small arithmetic helpers
// for the Game of Life generation sequencer.
package life_pkg;

    typedef enum logic [2:0] {
        IDLE, CLR, G_START, G_LOAD0, G_CALC, G_SWAP, W_RD, W_MOD
    } state_e;

    // B3/S23: a dead cell is born on exactly 3 neighbours, a live one survives on 2 or 3.
    localparam logic [3:0] BIRTH_N     = 4'd3;
    localparam logic [3:0] SURVIVE_MIN = 4'd2;
    localparam logic [3:0] SURVIVE_MAX = 4'd3;

    // Widest row the popcount helper handles.
    localparam int POP_W = 64;

    function automatic logic cell_next(input logic alive, input logic [3:0] nbr);
        logic nxt;
        if (alive) nxt = (nbr >= SURVIVE_MIN) && (nbr <= SURVIVE_MAX);
        else       nxt = (nbr == BIRTH_N);
        return nxt;
    endfunction

    function automatic logic [6:0] popcount(input logic [POP_W-1:0] v);
        logic [6:0] n;
        n = '0;
        for (int i = 0; i < POP_W; i++) n = n + 7'(v[i]);
        return n;
    endfunction

    // Two-digit BCD increment, 99 wraps to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] bcd);
        logic [3:0] ones;
        logic [3:0] tens;
        ones = bcd[3:0];
        tens = bcd[7:4];
        if (ones == 4'd9) begin
            ones = 4'd0;
            tens = (tens == 4'd9) ? 4'd0 : tens + 4'd1;
        end else begin
            ones = ones + 4'd1;
        end
        return {tens, ones};
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// Combinational next-generation evaluation of one grid row from its upper,
// own and lower rows; cells beyond the left/right edge count as dead.
module life_row_eval import life_pkg::*; #(
    parameter int COLS = 40
) (
    input  logic [COLS-1:0] prev_i,
    input  logic [COLS-1:0] cur_i,
    input  logic [COLS-1:0] nxt_i,
    output logic [COLS-1:0] next_o
);

    // One dead guard column on each side removes all edge special cases.
    logic [COLS+1:0] p_ext;
    logic [COLS+1:0] c_ext;
    logic [COLS+1:0] n_ext;

    assign p_ext = {1'b0, prev_i, 1'b0};
    assign c_ext = {1'b0, cur_i,  1'b0};
    assign n_ext = {1'b0, nxt_i,  1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic [3:0] nbr;
        assign nbr = 4'(p_ext[c]) + 4'(p_ext[c+1]) + 4'(p_ext[c+2])
                   + 4'(c_ext[c])                  + 4'(c_ext[c+2])
                   + 4'(n_ext[c]) + 4'(n_ext[c+1]) + 4'(n_ext[c+2]);
        assign next_o[c] = cell_next(c_ext[c+1], nbr);
    end

endmodule

// File: rtl/life_gen_sequencer.sv
// Steps Game of Life generations over a double-banked row memory and arbitrates
// that memory between generation, cursor read-modify-write and grid clear.
module life_gen_sequencer import life_pkg::*; #(
    parameter int ROWS  = 30,
    parameter int COLS  = 40,
    parameter int ROW_W = 5,
    parameter int COL_W = 6,
    parameter int CNT_W = 11
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             run,
    input  logic             clear,
    input  logic             wr_req,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  logic             wr_val,
    output logic             wr_ack,
    output logic             rd_en,
    output logic             rd_bank,
    output logic [ROW_W-1:0] rd_row,
    input  logic [COLS-1:0]  rd_data,
    output logic             we,
    output logic             wr_bank,
    output logic [ROW_W-1:0] wa_row,
    output logic [COLS-1:0]  wd,
    output logic             disp_bank,
    output logic             busy,
    output logic [3:0]       gen_ones,
    output logic [3:0]       gen_tens,
    output logic [CNT_W-1:0] live_count,
    output logic             tick_drop
);

    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(COLS - 1);

    state_e           state_q;
    logic [ROW_W-1:0] row_q;
    logic [COLS-1:0]  prev_q, cur_q;
    logic [CNT_W-1:0] acc_q, live_q;
    logic             disp_q;
    logic [7:0]       gen_q;
    logic             tick_pend_q, clr_pend_q, tick_drop_q;
    logic [ROW_W-1:0] w_row_q;
    logic [COL_W-1:0] w_col_q;
    logic             w_val_q;

    logic             tick_hit, clear_any, start_clr, start_gen;
    logic             tick_pend_d, clr_pend_d, tick_drop_d;
    logic             last_row;
    logic [COLS-1:0]  nxt_row_d, eval_row, w_mask, w_word_d;
    logic [CNT_W-1:0] acc_d;
    logic             w_in_range, w_old_bit, w_changed;

    assign tick_hit  = tick && run;
    assign clear_any = clear || clr_pend_q;
    assign start_clr = (state_q == IDLE) && clear_any;
    assign start_gen = (state_q == IDLE) && !clear_any && !wr_req && tick_pend_q && run;

    // A tick arriving on the very cycle the pending one is consumed re-arms the flag.
    assign tick_pend_d = tick_hit || (tick_pend_q && !start_gen);
    assign tick_drop_d = tick_hit && tick_pend_q && !start_gen;
    assign clr_pend_d  = clear_any && !start_clr;

    assign last_row  = (row_q == LAST_ROW);
    assign nxt_row_d = last_row ? '0 : rd_data;

    life_row_eval #(.COLS(COLS)) u_row_eval (
        .prev_i (prev_q),
        .cur_i  (cur_q),
        .nxt_i  (nxt_row_d),
        .next_o (eval_row)
    );

    assign acc_d = acc_q + CNT_W'(popcount(POP_W'(eval_row)));

    assign w_in_range = (w_row_q <= LAST_ROW) && (w_col_q <= LAST_COL);
    assign w_mask     = COLS'(1) << w_col_q;
    assign w_old_bit  = |(rd_data & w_mask);
    assign w_word_d   = w_val_q ? (rd_data | w_mask) : (rd_data & ~w_mask);
    assign w_changed  = w_in_range && (w_old_bit != w_val_q);

    // Memory port is decoded from the current state so reads and writes land in
    // the state cycle itself.
    always_comb begin
        // NOTE: every signal gets a default before the case so no latch is inferred.
        rd_en   = 1'b0;
        rd_bank = 1'b0;
        rd_row  = '0;
        we      = 1'b0;
        wr_bank = 1'b0;
        wa_row  = '0;
        wd      = '0;
        case (state_q)
            G_START: begin rd_en = 1'b1; rd_bank = disp_q; rd_row = '0; end
            G_LOAD0: begin rd_en = 1'b1; rd_bank = disp_q; rd_row = ROW_W'(1); end
            G_CALC: begin
                rd_en   = (row_q < ROW_W'(ROWS - 2));
                rd_bank = disp_q;
                rd_row  = row_q + ROW_W'(2);
                we      = 1'b1;
                wr_bank = ~disp_q;
                wa_row  = row_q;
                wd      = eval_row;
            end
            CLR: begin we = 1'b1; wr_bank = disp_q; wa_row = row_q; end
            W_RD: begin rd_en = (w_row_q <= LAST_ROW); rd_bank = disp_q; rd_row = w_row_q; end
            W_MOD: begin
                we      = w_in_range;
                wr_bank = disp_q;
                wa_row  = w_row_q;
                wd      = w_in_range ? w_word_d : '0;
            end
            default: ;
        endcase
        if (reset) we = 1'b0;
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state is assigned with <= only, so every register sees
        // the pre-edge value of every other register.
        if (reset) begin
            state_q     <= IDLE;
            row_q       <= '0;
            // NOTE: the cell RAM is external and never cleared by reset; only
            // the row pipeline registers here are.
            prev_q      <= '0;
            cur_q       <= '0;
            acc_q       <= '0;
            live_q      <= '0;
            disp_q      <= 1'b0;
            gen_q       <= '0;
            tick_pend_q <= 1'b0;
            clr_pend_q  <= 1'b0;
            tick_drop_q <= 1'b0;
            w_row_q     <= '0;
            w_col_q     <= '0;
            w_val_q     <= 1'b0;
        end else begin
            tick_pend_q <= tick_pend_d;
            clr_pend_q  <= clr_pend_d;
            tick_drop_q <= tick_drop_d;
            case (state_q)
                IDLE: begin
                    if (start_clr) begin
                        state_q <= CLR;
                        row_q   <= '0;
                        gen_q   <= '0;
                        live_q  <= '0;
                    end else if (wr_req) begin
                        state_q <= W_RD;
                        w_row_q <= wr_row;
                        w_col_q <= wr_col;
                        w_val_q <= wr_val;
                    end else if (start_gen) begin
                        state_q <= G_START;
                    end
                end
                CLR: begin
                    if (last_row) state_q <= IDLE;
                    else          row_q   <= row_q + ROW_W'(1);
                end
                G_START: state_q <= G_LOAD0;
                G_LOAD0: begin
                    prev_q  <= '0;
                    cur_q   <= rd_data;
                    row_q   <= '0;
                    acc_q   <= '0;
                    state_q <= G_CALC;
                end
                G_CALC: begin
                    prev_q <= cur_q;
                    cur_q  <= nxt_row_d;
                    acc_q  <= acc_d;
                    if (last_row) state_q <= G_SWAP;
                    else          row_q   <= row_q + ROW_W'(1);
                end
                G_SWAP: begin
                    disp_q  <= ~disp_q;
                    live_q  <= acc_q;
                    gen_q   <= bcd_inc(gen_q);
                    state_q <= IDLE;
                end
                W_RD: state_q <= W_MOD;
                W_MOD: begin
                    if (w_changed) live_q <= w_val_q ? live_q + CNT_W'(1) : live_q - CNT_W'(1);
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wr_ack     = (state_q == W_MOD);
    assign busy       = (state_q != IDLE);
    assign disp_bank  = disp_q;
    assign gen_ones   = gen_q[3:0];
    assign gen_tens   = gen_q[7:4];
    assign live_count = live_q;
    assign tick_drop  = tick_drop_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer with a behavioural double-banked row RAM.
module tb_life_gen_sequencer;

    localparam int ROWS  = 30;
    localparam int COLS  = 40;
    localparam int ROW_W = 5;
    localparam int COL_W = 6;
    localparam int CNT_W = 11;

    logic             clk = 1'b0;
    logic             reset, tick, run, clear, wr_req, wr_val;
    logic [ROW_W-1:0] wr_row;
    logic [COL_W-1:0] wr_col;
    logic             wr_ack, rd_en, rd_bank, we, wr_bank, disp_bank, busy, tick_drop;
    logic [ROW_W-1:0] rd_row, wa_row;
    logic [COLS-1:0]  rd_data = '0;
    logic [COLS-1:0]  wd;
    logic [3:0]       gen_ones, gen_tens;
    logic [CNT_W-1:0] live_count;

    logic [COLS-1:0]  mem [0:1][0:ROWS-1] = '{default: '0};

    int vectors     = 0;
    int miscompares = 0;

    life_gen_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .run(run), .clear(clear),
        .wr_req(wr_req), .wr_row(wr_row), .wr_col(wr_col), .wr_val(wr_val),
        .wr_ack(wr_ack), .rd_en(rd_en), .rd_bank(rd_bank), .rd_row(rd_row),
        .rd_data(rd_data), .we(we), .wr_bank(wr_bank), .wa_row(wa_row), .wd(wd),
        .disp_bank(disp_bank), .busy(busy), .gen_ones(gen_ones), .gen_tens(gen_tens),
        .live_count(live_count), .tick_drop(tick_drop)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (we && wa_row < ROW_W'(ROWS)) mem[wr_bank][wa_row] <= wd;
        if (rd_en && rd_row < ROW_W'(ROWS)) rd_data <= mem[rd_bank][rd_row];
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    // Waits (bounded) for busy to rise, then counts busy cycles until IDLE.
    task automatic wait_busy_window(output int cycles);
        int guard;
        guard  = 0;
        cycles = 0;
        while (!busy && guard < 20) begin step(); guard++; end
        while (busy && cycles < 400) begin step(); cycles++; end
    endtask

    // Holds wr_req until wr_ack, returning the cycles from request to ack.
    task automatic cursor_write(input int row, input int col, input logic val,
                                output int lat, output logic we_at_ack);
        wr_row = ROW_W'(row);
        wr_col = COL_W'(col);
        wr_val = val;
        wr_req = 1'b1;
        lat    = 0;
        do begin step(); lat++; end while (!wr_ack && lat < 10);
        we_at_ack = we;
        wr_req    = 1'b0;
        step();
    endtask

    function automatic int nz_rows(input int bank);
        int n;
        n = 0;
        for (int r = 0; r < ROWS; r++) if (mem[bank][r] != '0) n++;
        return n;
    endfunction

    initial begin
        int               lat, cyc, guard;
        logic             wa;
        logic [COLS-1:0]  exp_row;

        reset = 1'b1; tick = 1'b0; run = 1'b1; clear = 1'b0;
        wr_req = 1'b0; wr_row = '0; wr_col = '0; wr_val = 1'b0;
        step(); step();
        reset = 1'b0;

        check("rst_busy", busy, 0);
        check("rst_disp", disp_bank, 0);
        check("rst_gen", {gen_tens, gen_ones}, 8'h00);
        check("rst_live", live_count, 0);
        check("rst_mem_strobes", {we, rd_en, wr_ack, tick_drop}, 4'b0000);

        // Cursor writes on an empty grid.
        cursor_write(5, 7, 1'b1, lat, wa);
        check("cw_latency", lat, 2);
        check("cw_we", wa, 1);
        check("cw_live", live_count, 1);
        exp_row = COLS'(1) << 7;
        check("cw_mem", mem[0][5], exp_row);
        cursor_write(5, 7, 1'b1, lat, wa);
        check("cw_rewrite_live", live_count, 1);
        cursor_write(31, 7, 1'b1, lat, wa);
        check("cw_oor_latency", lat, 2);
        check("cw_oor_we", wa, 0);
        check("cw_oor_live", live_count, 1);
        cursor_write(5, 7, 1'b0, lat, wa);
        check("cw_erase_live", live_count, 0);
        check("cw_erase_mem", mem[0][5], 0);

        // Blinker: horizontal on row 14, columns 19..21.
        for (int c = 19; c <= 21; c++) cursor_write(14, c, 1'b1, lat, wa);
        check("blk_pre_live", live_count, 3);
        pulse_tick();
        wait_busy_window(cyc);
        check("blink_cycles", cyc, 33);
        check("blink_disp", disp_bank, 1);
        exp_row = COLS'(1) << 20;
        check("blink_r13", mem[1][13], exp_row);
        check("blink_r14", mem[1][14], exp_row);
        check("blink_r15", mem[1][15], exp_row);
        check("blink_rows", nz_rows(1), 3);
        check("blink_live", live_count, 3);
        check("blink_gen", {gen_tens, gen_ones}, 8'h01);
        pulse_tick();
        wait_busy_window(cyc);
        exp_row = COLS'(7) << 19;
        check("blink2_r14", mem[0][14], exp_row);
        check("blink2_rows", nz_rows(0), 1);
        check("blink2_disp", disp_bank, 0);
        check("blink2_gen", {gen_tens, gen_ones}, 8'h02);

        // tick and clear together: clear first, then the pending generation.
        tick = 1'b1; clear = 1'b1;
        step();
        tick = 1'b0; clear = 1'b0;
        wait_busy_window(cyc);
        check("tc_clr_cycles", cyc, 30);
        check("tc_clr_gen", {gen_tens, gen_ones}, 8'h00);
        check("tc_clr_live", live_count, 0);
        check("tc_clr_rows", nz_rows(0), 0);
        wait_busy_window(cyc);
        check("tc_gen_cycles", cyc, 33);
        check("tc_gen_gen", {gen_tens, gen_ones}, 8'h01);
        check("tc_gen_disp", disp_bank, 1);

        // Corner block must stay static.
        pulse_clear();
        wait_busy_window(cyc);
        check("clr_cycles", cyc, 30);
        check("clr_gen", {gen_tens, gen_ones}, 8'h00);
        cursor_write(0, 0, 1'b1, lat, wa);
        cursor_write(0, 1, 1'b1, lat, wa);
        cursor_write(1, 0, 1'b1, lat, wa);
        cursor_write(1, 1, 1'b1, lat, wa);
        check("block_pre_live", live_count, 4);
        for (int i = 0; i < 5; i++) begin
            pulse_tick();
            wait_busy_window(cyc);
        end
        check("block_gen", {gen_tens, gen_ones}, 8'h05);
        check("block_live", live_count, 4);
        check("block_disp", disp_bank, 0);
        check("block_r0", mem[0][0], 3);
        check("block_r1", mem[0][1], 3);
        check("block_rows", nz_rows(0), 2);

        // One tick pends during a generation, the next one is dropped.
        pulse_tick();
        guard = 0;
        while (!busy && guard < 20) begin step(); guard++; end
        repeat (3) step();
        pulse_tick();
        check("pend_no_drop", tick_drop, 0);
        repeat (3) step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        check("drop_pulse", tick_drop, 1);
        step();
        check("drop_pulse_end", tick_drop, 0);
        guard = 0;
        while (busy && guard < 100) begin step(); guard++; end
        wait_busy_window(cyc);
        check("pend_cycles", cyc, 33);
        repeat (3) step();
        check("pend_no_third", busy, 0);
        check("pend_gen", {gen_tens, gen_ones}, 8'h07);
        check("pend_live", live_count, 4);

        // Generation counter wrap.
        for (int i = 0; i < 92; i++) begin
            pulse_tick();
            wait_busy_window(cyc);
        end
        check("gen_99", {gen_tens, gen_ones}, 8'h99);
        pulse_tick();
        wait_busy_window(cyc);
        check("gen_wrap", {gen_tens, gen_ones}, 8'h00);
        check("gen_wrap_live", live_count, 4);
        check("gen_wrap_disp", disp_bank, 1);

        // Clear during a generation waits for G_SWAP.
        pulse_tick();
        guard = 0;
        while (!busy && guard < 20) begin step(); guard++; end
        repeat (5) step();
        pulse_clear();
        cyc = 0;
        while (busy && cyc < 100) begin step(); cyc++; end
        check("cdg_gen_done", {gen_tens, gen_ones}, 8'h01);
        check("cdg_disp", disp_bank, 0);
        wait_busy_window(cyc);
        check("cdg_clr_cycles", cyc, 30);
        check("cdg_gen", {gen_tens, gen_ones}, 8'h00);
        check("cdg_live", live_count, 0);
        check("cdg_rows", nz_rows(0), 0);

        // Reset in G_CALC row 10 abandons the generation.
        pulse_tick();
        guard = 0;
        while (!busy && guard < 20) begin step(); guard++; end
        repeat (12) step();
        check("r10_we", we, 1);
        check("r10_wa_row", wa_row, 10);
        check("r10_rd_row", rd_row, 12);
        check("r10_wr_bank", wr_bank, 1);
        reset = 1'b1;
        #1;
        check("r10_we_in_reset", we, 0);
        step();
        reset = 1'b0;
        check("r10_busy", busy, 0);
        check("r10_disp", disp_bank, 0);
        check("r10_gen", {gen_tens, gen_ones}, 8'h00);
        check("r10_live", live_count, 0);
        check("r10_strobes", {we, rd_en, wr_ack, tick_drop}, 4'b0000);
        repeat (3) step();
        check("r10_stays_idle", busy, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
